ysyx_23060240_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060240_mem_arbiter

Overview:
- Shares the single data-memory port (the DPI-backed pmem path) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Arbitrates between the two, issues one transaction at a time over a valid/ready request channel, and routes the response back to the owner.
- Sits between the IFU/LSU stages and the memory block; replaces direct combinational pmem access in the multi-cycle core.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive LSU wins allowed while IFU waits; minimum 1
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU fetch address
- ifu_rsp_valid  out  1  one-cycle response pulse to IFU
- ifu_rsp_data  out  DATA_W  fetched word
- ifu_rsp_err  out  1  error flag
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  DATA_W/8  byte enables
- lsu_rsp_valid  out  1  one-cycle response pulse to LSU; also sent for writes
- lsu_rsp_rdata  out  DATA_W  read data; 0 for writes
- lsu_rsp_err  out  1  error flag
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  address
- mem_req_wen  out  1  write enable
- mem_req_wdata  out  DATA_W  write data
- mem_req_wmask  out  DATA_W/8  byte enables
- mem_rsp_valid  in  1  memory response strobe
- mem_rsp_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; all outputs and registers are 0, including the starvation counter. Reset mid-transaction abandons it silently; no response is issued.
- FSM state IDLE:
  - If either request is valid, pick the owner: LSU wins unless starve_cnt == STARVE_MAX and ifu_req_valid is high.
  - Assert the owner's req_ready combinationally this cycle, latch addr/wen/wdata/wmask/owner, and go to REQ.
  - IFU requests always latch as wen=0, wmask=0.
- FSM state REQ:
  - mem_req_* driven from the latched registers.
  - On mem_req_valid && mem_req_ready, go to WAIT.
  - mem_req_valid stays high with stable payload until accepted.
- FSM state WAIT:
  - On mem_rsp_valid, register the data into the owner's rsp_data/rdata and pulse the owner's rsp_valid for exactly the next cycle. Go to IDLE.
  - LSU writes return rdata = 0.
- Request/response rules:
  - Only one outstanding transaction. req_ready is never high outside IDLE.
  - mem_rsp_valid outside WAIT is ignored.
  - Responses have no back-pressure; requesters must always accept them.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, mem response at cycle 2 with ready=1 at cycle 1, owner rsp_valid at cycle 3.
- Back-to-back: a new accept can occur in the IDLE cycle that coincides with the rsp_valid pulse.
- Starvation counter (starve_cnt, width clog2(STARVE_MAX+1)):
  - Increments, saturating, on each LSU grant made while ifu_req_valid=1.
  - Clears on any IFU grant.
- Requesters must hold valid and payload stable until ready. A dropped valid before acceptance is legal and simply not served.

Optional Feature:
- Macro: YSYX_23060240_MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in REQ and WAIT.
  - On reaching TIMEOUT_CYCLES, the owner gets rsp_valid with err=1 and data 0, mem_req_valid drops, and the FSM goes to IDLE.
  - A late mem_rsp_valid in IDLE is discarded.
- Without the macro: no counter, the FSM waits indefinitely, and both err outputs are tied to 0.

Decomposition:
- Package ysyx_23060240_mem_pkg: state enum (IDLE/REQ/WAIT), owner enum (OWN_IFU/OWN_LSU), default ADDR_W/DATA_W constants.
- One sub-module, ysyx_23060240_mem_arb_pick: combinational priority select plus the registered starvation counter. The FSM and datapath latches stay in the top.

Test Plan:
- Lone IFU read to 0x8000_0000, memory returns 0x0000_0413 two cycles after accept -> ifu_rsp_valid pulses 1 cycle with 0x0000_0413; lsu_rsp_valid stays 0.
- Both requesters valid in the same cycle, IFU 0x8000_0004 and LSU read 0x8000_1000 -> LSU granted first; IFU granted on the next IDLE.
- LSU issues continuous requests with IFU held valid, STARVE_MAX=4 -> exactly 4 LSU grants, then 1 IFU grant, then the counter is 0.
- LSU write of 0xDEADBEEF, wmask 4'b0011, mem_req_ready low for 3 cycles -> mem_req payload stable for all 3 cycles; lsu_rsp_valid pulses with rdata=0.
- rst_n asserted low while in WAIT -> all outputs 0 immediately; the following mem_rsp_valid produces no response.
- Timeout macro defined, TIMEOUT_CYCLES=16, memory never responds -> owner receives err=1 and data 0 at cycle 16; a later mem_rsp_valid is ignored.

Source files
------------

// File: rtl/ysyx_23060240_mem_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_23060240_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // One transaction in flight: accept in IDLE, present in REQ, await data in WAIT
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // Which requester owns the transaction currently in flight
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_23060240_mem_arb_pick.sv
// Priority select between IFU and LSU, with a saturating IFU starvation counter.
// Latency: grant is combinational; the counter updates on the grant edge.
// Backpressure: grants only while arb_en_i is high (arbiter idle).
module ysyx_23060240_mem_arb_pick
    import ysyx_23060240_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en_i,
    input  logic       ifu_vld_i,
    input  logic       lsu_vld_i,
    output logic       grant_vld_o,
    output arb_owner_e grant_own_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    // IFU gets its turn only once the LSU has won STARVE_MAX times in a row over it
    assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // LSU wins by default; a starved, waiting IFU overrides it
    always_comb begin
        grant_vld_o = arb_en_i && (ifu_vld_i || lsu_vld_i);
        grant_own_o = OWN_IFU;
        if (lsu_vld_i && !(starved && ifu_vld_i)) begin
            grant_own_o = OWN_LSU;
        end
    end

    // Count LSU wins that made the IFU wait; any IFU win resets the streak
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_vld_o) begin
            if (grant_own_o == OWN_IFU) begin
                starve_cnt_d = '0;
            end else if (ifu_vld_i && !starved) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Shares one memory request/response port between IFU and LSU, one transaction at a time.
// Latency: accept at 0, mem_req_valid at 1, owner rsp_valid one cycle after mem_rsp_valid (min 3).
// Backpressure: req_ready only in IDLE; mem_req held stable until mem_req_ready; responses unthrottled.
// Optional watchdog: define YSYX_23060240_MEM_ARB_TIMEOUT_EN to abort stuck transactions with err=1.
module ysyx_23060240_mem_arbiter
    import ysyx_23060240_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                ifu_rsp_vld_q, ifu_rsp_vld_d;
    logic [DATA_W-1:0]   ifu_rsp_dat_q, ifu_rsp_dat_d;
    logic                lsu_rsp_vld_q, lsu_rsp_vld_d;
    logic [DATA_W-1:0]   lsu_rsp_dat_q, lsu_rsp_dat_d;

    logic                grant_vld;
    arb_owner_e          grant_own;

`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                ifu_err_q, ifu_err_d;
    logic                lsu_err_q, lsu_err_d;
    logic                tmo_hit;
`else
    logic                tmo_unused;
    assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

    ysyx_23060240_mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en_i    (state_q == IDLE),
        .ifu_vld_i   (ifu_req_valid),
        .lsu_vld_i   (lsu_req_valid),
        .grant_vld_o (grant_vld),
        .grant_own_o (grant_own)
    );

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign ifu_rsp_valid = ifu_rsp_vld_q;
    assign ifu_rsp_data  = ifu_rsp_dat_q;
    assign lsu_rsp_valid = lsu_rsp_vld_q;
    assign lsu_rsp_rdata = lsu_rsp_dat_q;

`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
    assign ifu_rsp_err = ifu_err_q;
    assign lsu_rsp_err = lsu_err_q;
    // tmo_q is the number of cycles since accept; abort on the edge where it would reach the limit
    assign tmo_hit     = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign ifu_rsp_err = 1'b0;
    assign lsu_rsp_err = 1'b0;
`endif

    // FSM next state, request latching, ready generation and response routing
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        ifu_rsp_vld_d = 1'b0;
        ifu_rsp_dat_d = ifu_rsp_dat_q;
        lsu_rsp_vld_d = 1'b0;
        lsu_rsp_dat_d = lsu_rsp_dat_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
        tmo_d         = (state_q == IDLE) ? TMO_W'(1) : tmo_q + TMO_W'(1);
        ifu_err_d     = 1'b0;
        lsu_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_own;
                    state_d = REQ;
                    if (grant_own == OWN_LSU) begin
                        lsu_req_ready = 1'b1;
                        addr_d        = lsu_req_addr;
                        wen_d         = lsu_req_wen;
                        wdata_d       = lsu_req_wdata;
                        wmask_d       = lsu_req_wmask;
                    end else begin
                        // Fetches are always plain reads
                        ifu_req_ready = 1'b1;
                        addr_d        = ifu_req_addr;
                        wen_d         = 1'b0;
                        wdata_d       = '0;
                        wmask_d       = '0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IFU) begin
                        ifu_rsp_vld_d = 1'b1;
                        ifu_rsp_dat_d = mem_rsp_rdata;
                    end else begin
                        lsu_rsp_vld_d = 1'b1;
                        lsu_rsp_dat_d = wen_q ? '0 : mem_rsp_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
        // A genuine response arriving on the deadline cycle takes precedence over the abort
        if (tmo_hit && !(state_q == WAIT && mem_rsp_valid)) begin
            state_d = IDLE;
            if (owner_q == OWN_IFU) begin
                ifu_rsp_vld_d = 1'b1;
                ifu_rsp_dat_d = '0;
                ifu_err_d     = 1'b1;
            end else begin
                lsu_rsp_vld_d = 1'b1;
                lsu_rsp_dat_d = '0;
                lsu_err_d     = 1'b1;
            end
        end
`endif
    end

    // State, latched request payload and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IFU;
            addr_q        <= '0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            ifu_rsp_vld_q <= 1'b0;
            ifu_rsp_dat_q <= '0;
            lsu_rsp_vld_q <= 1'b0;
            lsu_rsp_dat_q <= '0;
`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
            tmo_q         <= '0;
            ifu_err_q     <= 1'b0;
            lsu_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            wen_q         <= wen_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            ifu_rsp_vld_q <= ifu_rsp_vld_d;
            ifu_rsp_dat_q <= ifu_rsp_dat_d;
            lsu_rsp_vld_q <= lsu_rsp_vld_d;
            lsu_rsp_dat_q <= lsu_rsp_dat_d;
`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
            tmo_q         <= tmo_d;
            ifu_err_q     <= ifu_err_d;
            lsu_err_q     <= lsu_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Latency: checks the 3-cycle accept-to-response path and back-to-back accepts.
// Backpressure: exercises mem_req_ready stalls and the starvation limit.
module tb_ysyx_23060240_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int          checks = 0;
    int          errors = 0;
    logic        mem_auto = 1'b0;
    int          gcount = 0;
    logic [7:0]  gseq = 8'h0;

    always #5 clk = ~clk;

    ysyx_23060240_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .STARVE_MAX     (4),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Automatic memory: answers one cycle after each handshake when mem_auto is set
    initial begin
        logic        hs;
        logic [31:0] haddr;
        forever begin
            @(negedge clk);
            hs    = mem_auto && mem_req_valid && mem_req_ready;
            haddr = mem_req_addr;
            @(posedge clk);
            #1;
            if (mem_auto) begin
                mem_rsp_valid = hs;
                mem_rsp_rdata = hs ? mem_model(haddr) : 32'h0;
            end
        end
    end

    // Grant log: shift in 1 for an IFU accept, 0 for an LSU accept
    initial begin
        forever begin
            @(negedge clk);
            if (ifu_req_valid && ifu_req_ready) begin
                gseq   = {gseq[6:0], 1'b1};
                gcount = gcount + 1;
            end
            if (lsu_req_valid && lsu_req_ready) begin
                gseq   = {gseq[6:0], 1'b0};
                gcount = gcount + 1;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        repeat (3) tick();
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_req_wen, ifu_rsp_err, lsu_rsp_err} !== 8'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_req_wen, ifu_rsp_err, lsu_rsp_err});
        end
        checks++;
        if ({mem_req_addr, mem_req_wdata, mem_req_wmask} !== 68'h0) begin
            errors++;
            $display("FAIL reset_mem_payload: got %h %h %h required 0", mem_req_addr, mem_req_wdata, mem_req_wmask);
        end
        checks++;
        if ({ifu_rsp_data, lsu_rsp_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rsp_data: got %h %h required 0", ifu_rsp_data, lsu_rsp_rdata);
        end
        checks++;
        if (u_dut.u_pick.starve_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_starve_cnt: got %0d required 0", u_dut.u_pick.starve_cnt_q);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lone_ifu;
        mem_auto = 0; mem_req_ready = 1; mem_rsp_valid = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ifu_accept: got %b required 10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 0; ifu_req_addr = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'h0}) begin
            errors++;
            $display("FAIL ifu_mem_req: got v=%b wen=%b addr=%h mask=%h required v=1 wen=0 addr=80000000 mask=0", mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask);
        end
        tick();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0413;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_wait_req_low: got %b required 0", mem_req_valid);
        end
        tick();
        mem_rsp_valid = 0; mem_rsp_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data} !== {2'b10, 32'h0000_0413}) begin
            errors++;
            $display("FAIL ifu_rsp: got ifu=%b lsu=%b data=%h required ifu=1 lsu=0 data=00000413", ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data);
        end
        tick();
        #1;
        checks++;
        if (ifu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_rsp_pulse: got %b required 0", ifu_rsp_valid);
        end
    endtask

    task automatic test_both_valid;
        mem_auto = 1; mem_req_ready = 1;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_1000; lsu_req_wmask = 4'hF;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL both_lsu_first: got %b required 01", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        lsu_req_valid = 0;
        #1;
        checks++;
        if ({ifu_req_ready, mem_req_addr} !== {1'b0, 32'h8000_1000}) begin
            errors++;
            $display("FAIL both_req_phase: got rdy=%b addr=%h required rdy=0 addr=80001000", ifu_req_ready, mem_req_addr);
        end
        tick();
        #1;
        checks++;
        if (ifu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_wait_no_ready: got %b required 0", ifu_req_ready);
        end
        tick();
        #1;
        checks++;
        if ({lsu_rsp_valid, lsu_rsp_rdata, ifu_req_ready} !== {1'b1, mem_model(32'h8000_1000), 1'b1}) begin
            errors++;
            $display("FAIL both_lsu_rsp_b2b: got v=%b d=%h ifu_rdy=%b required v=1 d=%h ifu_rdy=1", lsu_rsp_valid, lsu_rsp_rdata, ifu_req_ready, mem_model(32'h8000_1000));
        end
        tick();
        ifu_req_valid = 0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr} !== {2'b10, 32'h8000_0004}) begin
            errors++;
            $display("FAIL both_ifu_req: got v=%b wen=%b addr=%h required v=1 wen=0 addr=80000004", mem_req_valid, mem_req_wen, mem_req_addr);
        end
        tick();
        tick();
        #1;
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_data} !== {1'b1, mem_model(32'h8000_0004)}) begin
            errors++;
            $display("FAIL both_ifu_rsp: got v=%b d=%h required v=1 d=%h", ifu_rsp_valid, ifu_rsp_data, mem_model(32'h8000_0004));
        end
    endtask

    task automatic test_starvation;
        mem_auto = 1; mem_req_ready = 1;
        tick();
        gcount = 0; gseq = 8'h0;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_2000;
        for (int c = 0; c < 80 && gcount < 5; c++) begin
            tick();
            if (gcount > 0 && gseq[0] === 1'b1) ifu_req_valid = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        checks++;
        if (gcount !== 5) begin
            errors++;
            $display("FAIL starve_grant_count: got %0d required 5", gcount);
        end
        checks++;
        if (gseq[4:0] !== 5'b00001) begin
            errors++;
            $display("FAIL starve_order: got %b required 00001 (L,L,L,L,I)", gseq[4:0]);
        end
        checks++;
        if (u_dut.u_pick.starve_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL starve_cnt_clear: got %0d required 0", u_dut.u_pick.starve_cnt_q);
        end
        repeat (5) tick();
    endtask

    task automatic test_write_stall;
        mem_auto = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_3000;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011;
        #1;
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept: got %b required 1", lsu_req_ready);
        end
        tick();
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0; lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_3000, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
                errors++;
                $display("FAIL wr_stall_stable[%0d]: got v=%b a=%h w=%b d=%h m=%b required v=1 a=80003000 w=1 d=deadbeef m=0011", i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
            end
            tick();
        end
        mem_req_ready = 1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_valid_held: got %b required 1", mem_req_valid);
        end
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 0;
        #1;
        checks++;
        if ({lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err, ifu_rsp_valid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wr_rsp: got v=%b d=%h err=%b ifu=%b required v=1 d=0 err=0 ifu=0", lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err, ifu_rsp_valid);
        end
        tick();
        #1;
        checks++;
        if (lsu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp_pulse: got %b required 0", lsu_rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        mem_auto = 0; mem_req_ready = 1; mem_rsp_valid = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
        tick();
        ifu_req_valid = 0;
        tick();
`ifndef YSYX_23060240_MEM_ARB_TIMEOUT_EN
        seen = 0;
        repeat (20) begin
            tick();
            if (ifu_rsp_valid || lsu_rsp_valid || ifu_rsp_err) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL wait_forever: got rsp seen=%b required 0", seen);
        end
`endif
        rst_n = 0;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_req_addr, ifu_rsp_data, lsu_rsp_rdata} !== 101'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got v=%b addr=%h ifu_d=%h lsu_d=%h required all 0", mem_req_valid, mem_req_addr, ifu_rsp_data, lsu_rsp_rdata);
        end
        tick();
        rst_n = 1;
        tick();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_1111;
        tick();
        mem_rsp_valid = 0;
        seen = 0;
        repeat (3) begin
            #1;
            if (ifu_rsp_valid || lsu_rsp_valid || mem_req_valid) seen = 1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_late_rsp: got activity=%b required 0", seen);
        end
    endtask

`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic seen;
        mem_auto = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_000C;
        tick();
        ifu_req_valid = 0;
        repeat (14) tick();
        #1;
        checks++;
        if ({ifu_rsp_valid, mem_req_valid} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_before: got rsp=%b req=%b required rsp=0 req=1", ifu_rsp_valid, mem_req_valid);
        end
        tick();
        #1;
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, mem_req_valid} !== {2'b11, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL tmo_fire: got v=%b err=%b d=%h req=%b required v=1 err=1 d=0 req=0", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, mem_req_valid);
        end
        tick();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h2222_2222;
        tick();
        mem_rsp_valid = 0;
        seen = 0;
        repeat (3) begin
            #1;
            if (ifu_rsp_valid || lsu_rsp_valid) seen = 1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late_rsp: got rsp=%b required 0", seen);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_ifu();
        test_both_valid();
        test_starvation();
        test_write_stall();
        test_reset_mid();
`ifdef YSYX_23060240_MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
